// File: rtl/exec_unit_if.sv
// ============================================================================
// exec_unit_if : request/result bundle between a requester and exec_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

interface exec_unit_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op;
  logic       valid_in;
  logic [7:0] ans_tmp;
  logic [7:0] data_out_buff;
  logic [7:0] B_ex;
  logic       carry;
  logic       zero;
  logic       dz;
  logic       busy;
  logic       done;

  modport master (
    output A, B, op, valid_in,
    input  ans_tmp, data_out_buff, B_ex, carry, zero, dz, busy, done
  );

  modport slave (
    input  A, B, op, valid_in,
    output ans_tmp, data_out_buff, B_ex, carry, zero, dz, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/exec_unit.sv
// ============================================================================
// exec_unit : 8-bit ALU with single-cycle logic/arith ops and 8-iteration
//             shift-add multiply / restoring divide.   Rev 1.0
// ============================================================================
`default_nettype none

module exec_unit (
  input wire logic   clk,
  input wire logic   reset,
  exec_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;

  logic [7:0]  ans_q, ans_d;
  logic [7:0]  dob_q, dob_d;
  logic [7:0]  bex_q, bex_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Single-cycle datapath
  logic [8:0]  sum9, diff9;
  logic [7:0]  alu_res, alu_hi;
  logic        alu_c, alu_dz;

  assign sum9  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff9 = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    alu_res = 8'h00;
    alu_hi  = 8'h00;
    alu_c   = 1'b0;
    alu_dz  = 1'b0;
    case (bus.op)
      OP_ADD: begin alu_res = sum9[7:0];  alu_c = sum9[8];  end
      OP_SUB: begin alu_res = diff9[7:0]; alu_c = diff9[8]; end
      OP_AND: alu_res = bus.A & bus.B;
      OP_OR:  alu_res = bus.A | bus.B;
      OP_XOR: alu_res = bus.A ^ bus.B;
      OP_SHL: begin alu_res = {bus.A[6:0], 1'b0}; alu_c = bus.A[7]; end
      // Only the divide-by-zero case ever completes a DIV here.
      OP_DIV: begin alu_res = 8'hFF; alu_hi = bus.A; alu_dz = 1'b1; end
      default: ;
    endcase
  end

  // Multiply step: add multiplicand into the high half when the LSB is set, then shift right.
  logic [8:0]  mul_add;
  logic [15:0] mul_step;
  assign mul_add  = {1'b0, prod_q[15:8]} + (prod_q[0] ? {1'b0, a_q} : 9'd0);
  assign mul_step = {mul_add, prod_q[7:1]};

  // Divide step: shift next dividend bit into the remainder and trial-subtract.
  logic [8:0]  div_sh;
  logic        div_ge;
  logic [7:0]  div_rem;
  logic [7:0]  div_quo;
  assign div_sh  = {rem_q, quo_q[7]};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_rem = div_ge ? (div_sh[7:0] - b_q) : div_sh[7:0];
  assign div_quo = {quo_q[6:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ans_d   = ans_q;
    dob_d   = dob_q;
    bex_d   = bex_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          bex_d = bus.B;
          if (bus.op == OP_MUL) begin
            state_d = S_MUL_RUN;
            cnt_d   = 3'd0;
            a_d     = bus.A;
            prod_d  = {8'h00, bus.B};
            busy_d  = 1'b1;
          end else if (bus.op == OP_DIV && bus.B != 8'h00) begin
            state_d = S_DIV_RUN;
            cnt_d   = 3'd0;
            b_d     = bus.B;
            quo_d   = bus.A;
            rem_d   = 8'h00;
            busy_d  = 1'b1;
          end else begin
            ans_d   = alu_res;
            dob_d   = alu_hi;
            carry_d = alu_c;
            dz_d    = alu_dz;
            zero_d  = (alu_res == 8'h00);
            done_d  = 1'b1;
          end
        end
      end

      S_MUL_RUN: begin
        prod_d = mul_step;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ans_d   = mul_step[7:0];
          dob_d   = mul_step[15:8];
          carry_d = 1'b0;
          dz_d    = 1'b0;
          zero_d  = (mul_step[7:0] == 8'h00);
        end
      end

      S_DIV_RUN: begin
        quo_d = div_quo;
        rem_d = div_rem;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ans_d   = div_quo;
          dob_d   = div_rem;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          zero_d  = (div_quo == 8'h00);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      prod_q  <= 16'h0000;
      quo_q   <= 8'h00;
      rem_q   <= 8'h00;
      ans_q   <= 8'h00;
      dob_q   <= 8'h00;
      bex_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ans_q   <= ans_d;
      dob_q   <= dob_d;
      bex_q   <= bex_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ans_tmp       = ans_q;
  assign bus.data_out_buff = dob_q;
  assign bus.B_ex          = bex_q;
  assign bus.carry         = carry_q;
  assign bus.zero          = zero_q;
  assign bus.dz            = dz_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ============================================================================
// tb_exec_unit : directed vectors for exec_unit with hand-computed results.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  exec_unit_if bus ();

  exec_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.op       = o;
    bus.A        = a;
    bus.B        = b;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  // Follows a multi-cycle op until busy drops; optionally pokes an ignored request.
  task automatic wait_busy(input logic inject, input logic [7:0] hold_ans,
                           output int busy_cycles, output int done_cnt);
    busy_cycles = bus.busy ? 1 : 0;
    done_cnt    = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(negedge clk);
      bus.valid_in = inject && (i == 1);
      bus.op       = 3'b000;
      bus.A        = 8'h01;
      bus.B        = 8'h77;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) done_cnt++;
      if (i == 3) chk("ans_hidden_while_busy", bus.ans_tmp, hold_ans);
    end
  endtask

  int bc, dc;

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.A        = 8'h00;
    bus.B        = 8'h00;
    bus.op       = 3'b000;
    bus.valid_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ans",   bus.ans_tmp, 8'h00);
    chk("rst_dob",   bus.data_out_buff, 8'h00);
    chk("rst_bex",   bus.B_ex, 8'h00);
    chk("rst_flags", {bus.carry, bus.zero, bus.dz, bus.busy, bus.done}, 5'b01000);
    @(negedge clk);
    reset = 1'b0;

    // ADD with carry out
    do_op(3'b000, 8'hF0, 8'h20);
    chk("add_ans",   bus.ans_tmp, 8'h10);
    chk("add_flags", {bus.carry, bus.zero, bus.dz, bus.done}, 4'b1001);
    chk("add_bex",   bus.B_ex, 8'h20);
    chk("add_dob",   bus.data_out_buff, 8'h00);
    @(posedge clk);
    #1;
    chk("done_clears", bus.done, 1'b0);
    chk("ans_holds",   bus.ans_tmp, 8'h10);

    // SUB back-to-back
    do_op(3'b001, 8'h05, 8'h05);
    chk("sub_eq_ans",   bus.ans_tmp, 8'h00);
    chk("sub_eq_flags", {bus.carry, bus.zero, bus.done}, 3'b011);
    do_op(3'b001, 8'h03, 8'h04);
    chk("sub_borrow_ans",   bus.ans_tmp, 8'hFF);
    chk("sub_borrow_flags", {bus.carry, bus.zero, bus.done}, 3'b101);

    // Logic ops and shift
    do_op(3'b010, 8'hA5, 8'h3C);
    chk("and_ans", bus.ans_tmp, 8'h24);
    chk("and_c",   bus.carry, 1'b0);
    do_op(3'b011, 8'hA5, 8'h3C);
    chk("or_ans", bus.ans_tmp, 8'hBD);
    do_op(3'b100, 8'hA5, 8'hA5);
    chk("xor_ans",  bus.ans_tmp, 8'h00);
    chk("xor_zero", bus.zero, 1'b1);
    do_op(3'b101, 8'h81, 8'hFF);
    chk("shl_ans",   bus.ans_tmp, 8'h02);
    chk("shl_flags", {bus.carry, bus.zero, bus.done}, 3'b101);

    // MUL 0xFF*0xFF with an ignored request during busy
    do_op(3'b110, 8'hFF, 8'hFF);
    chk("mul_accept", {bus.busy, bus.done}, 2'b10);
    wait_busy(1'b1, 8'h02, bc, dc);
    chk("mul_busy_cycles", bc[15:0], 16'd8);
    chk("mul_done_cnt",    dc[15:0], 16'd1);
    chk("mul_ans",   bus.ans_tmp, 8'h01);
    chk("mul_dob",   bus.data_out_buff, 8'hFE);
    chk("mul_flags", {bus.carry, bus.zero, bus.dz, bus.busy}, 4'b0000);
    chk("mul_bex",   bus.B_ex, 8'hFF);

    // DIV accepted in the done cycle of MUL
    do_op(3'b111, 8'hC8, 8'h07);
    chk("div_accept", {bus.busy, bus.done}, 2'b10);
    chk("div_bex",    bus.B_ex, 8'h07);
    wait_busy(1'b0, 8'h01, bc, dc);
    chk("div_busy_cycles", bc[15:0], 16'd8);
    chk("div_ans",   bus.ans_tmp, 8'h1C);
    chk("div_dob",   bus.data_out_buff, 8'h04);
    chk("div_flags", {bus.carry, bus.dz, bus.done}, 3'b001);

    // Divide by zero
    do_op(3'b111, 8'h5A, 8'h00);
    chk("dz_ans",   bus.ans_tmp, 8'hFF);
    chk("dz_dob",   bus.data_out_buff, 8'h5A);
    chk("dz_flags", {bus.dz, bus.busy, bus.done, bus.zero}, 4'b1010);

    // Reset mid-MUL
    do_op(3'b110, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ans",   bus.ans_tmp, 8'h00);
    chk("abort_dob",   bus.data_out_buff, 8'h00);
    chk("abort_bex",   bus.B_ex, 8'h00);
    chk("abort_flags", {bus.carry, bus.zero, bus.dz, bus.busy, bus.done}, 5'b01000);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", {bus.busy, bus.done}, 2'b00);
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.op       = 3'b000;
    bus.A        = 8'h01;
    bus.B        = 8'h01;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    chk("post_rst_add", bus.ans_tmp, 8'h02);
    chk("post_rst_flags", {bus.carry, bus.dz, bus.done, bus.busy}, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
